demux_2to1_fifo: RTL and testbench

- Sequential inverse of the board-level 2-to-1 selector: accepts one stream of tagged words and steers each word to channel A or channel B.
- Each channel has a small FIFO and a valid/ready output handshake.
- Sits between a shared time-multiplexed source (switch or word bus) and two independent consumers (LED/display drivers or downstream blocks).

---
 rtl/demux_2to1_fifo.sv | 126 ++++++++++++
 tb/tb_demux_2to1_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_2to1_fifo.sv
// demux_2to1_fifo: steers one stream of tagged words into two independent
// channel FIFOs (A when in_sel = 0, B when in_sel = 1), each with a
// valid/ready output handshake.
//
// Ports:
//   clock, resetn        system clock, asynchronous active-low reset
//   in_data/in_sel       offered word and its destination tag
//   in_valid/in_ready    input handshake; in_ready reflects the tagged channel
//   a_data/a_valid/a_ready, b_data/b_valid/b_ready   per-channel output handshake
//   a_count/b_count      per-channel occupancy, 0..DEPTH

// One channel FIFO: storage, wrapping pointers and occupancy count.
module demux_2to1_fifo_chan #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     ready,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;

  assign pop   = ready & valid;
  assign full  = (count == CNT_W'(DEPTH));
  assign valid = (count != '0);
  // Head word is only visible while the channel holds data.
  assign data  = valid ? mem[rd_ptr] : '0;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module demux_2to1_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       a_data,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [WIDTH-1:0]       b_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);

  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;

  // Full channel refuses the word even if its consumer pops this cycle.
  assign in_ready = in_sel ? ~full_b : ~full_a;
  assign push_a   = in_valid & ~in_sel & ~full_a;
  assign push_b   = in_valid &  in_sel & ~full_b;

  demux_2to1_fifo_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_a (
    .clock   (clock),
    .resetn  (resetn),
    .push    (push_a),
    .wr_data (in_data),
    .ready   (a_ready),
    .data    (a_data),
    .valid   (a_valid),
    .full    (full_a),
    .count   (a_count)
  );

  demux_2to1_fifo_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_b (
    .clock   (clock),
    .resetn  (resetn),
    .push    (push_b),
    .wr_data (in_data),
    .ready   (b_ready),
    .data    (b_data),
    .valid   (b_valid),
    .full    (full_b),
    .count   (b_count)
  );

endmodule

// File: tb/tb_demux_2to1_fifo.sv
// tb_demux_2to1_fifo: directed scenarios plus a randomized run, each
// checked against two queues that model the channel FIFOs.
//
// Ports: none (top-level bench).
module tb_demux_2to1_fifo;

  localparam int DEPTH = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready = 1'b0;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready = 1'b0;
  logic [1:0] a_count;
  logic [1:0] b_count;

  int total = 0;
  int bad = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] pa[$];
  logic [7:0] pb[$];

  demux_2to1_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clock = ~clock;

  // Advance one clock; model queues follow the FIFO rules, DUT heads
  // presented at each pop are logged for ordering checks.
  task automatic tick();
    bit acc_a, acc_b, pop_a, pop_b;
    logic [7:0] d, tmp;
    acc_a = in_valid && !in_sel && qa.size() < DEPTH;
    acc_b = in_valid &&  in_sel && qb.size() < DEPTH;
    pop_a = a_ready && qa.size() > 0;
    pop_b = b_ready && qb.size() > 0;
    if (pop_a) pa.push_back(a_data);
    if (pop_b) pb.push_back(b_data);
    d = in_data;
    @(posedge clock);
    #1;
    if (pop_a) tmp = qa.pop_front();
    if (pop_b) tmp = qb.pop_front();
    if (acc_a) qa.push_back(d);
    if (acc_b) qb.push_back(d);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = 8'h00;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b1;
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    total++;
    if ({a_valid, b_valid, a_count, b_count, a_data, b_data} !== 22'd0) begin
      bad++;
      $display("FAIL reset_async: got av=%0b bv=%0b ac=%0d bc=%0d ad=%h bd=%h, want all 0",
               a_valid, b_valid, a_count, b_count, a_data, b_data);
    end
    qa.delete(); qb.delete();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    tick(); tick();
    total++;
    if ({a_valid, b_valid, a_count, b_count, a_data, b_data} !== 22'd0) begin
      bad++;
      $display("FAIL reset_idle: got av=%0b bv=%0b ac=%0d bc=%0d ad=%h bd=%h, want all 0",
               a_valid, b_valid, a_count, b_count, a_data, b_data);
    end
    in_sel = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    in_sel = 1'b0;
  endtask

  task automatic test_steering();
    idle_inputs();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5;
    tick();
    total++;
    if (a_valid !== 1'b1 || a_data !== 8'hA5 || a_count !== 2'd1 || b_valid !== 1'b0) begin
      bad++;
      $display("FAIL steer_a: got av=%0b ad=%h ac=%0d bv=%0b want 1 a5 1 0",
               a_valid, a_data, a_count, b_valid);
    end
    in_sel = 1'b1; in_data = 8'h3C;
    tick();
    total++;
    if (b_valid !== 1'b1 || b_data !== 8'h3C || b_count !== 2'd1 ||
        a_data !== 8'hA5 || a_count !== 2'd1) begin
      bad++;
      $display("FAIL steer_b: got bv=%0b bd=%h bc=%0d ad=%h ac=%0d want 1 3c 1 a5 1",
               b_valid, b_data, b_count, a_data, a_count);
    end
    idle_inputs();
    a_ready = 1'b1; b_ready = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (a_count !== 2'd0 || b_count !== 2'd0 || a_data !== 8'h00 || b_data !== 8'h00) begin
      bad++;
      $display("FAIL steer_drain: got ac=%0d bc=%0d ad=%h bd=%h want 0 0 00 00",
               a_count, b_count, a_data, b_data);
    end
  endtask

  task automatic test_full_backpressure();
    idle_inputs();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h01;
    tick();
    in_data = 8'h02;
    tick();
    in_data = 8'h03;
    #1;
    total++;
    if (in_ready !== 1'b0 || a_count !== 2'd2) begin
      bad++;
      $display("FAIL full_a_ready: got rdy=%0b ac=%0d want 0 2", in_ready, a_count);
    end
    in_sel = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_other_ready: got %0b want 1", in_ready);
    end
    tick();
    total++;
    if (b_data !== 8'h03 || b_count !== 2'd1 || a_count !== 2'd2 || a_data !== 8'h01) begin
      bad++;
      $display("FAIL full_other_accept: got bd=%h bc=%0d ac=%0d ad=%h want 03 1 2 01",
               b_data, b_count, a_count, a_data);
    end
  endtask

  // Continues from A full with 01,02.
  task automatic test_full_pop();
    idle_inputs();
    b_ready = 1'b1;
    tick();
    pa.delete();
    idle_inputs();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h09; a_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || a_count !== 2'd2) begin
      bad++;
      $display("FAIL fullpop_ready: got rdy=%0b ac=%0d want 0 2", in_ready, a_count);
    end
    tick();
    total++;
    if (a_count !== 2'd1 || a_data !== 8'h02) begin
      bad++;
      $display("FAIL fullpop_after: got ac=%0d ad=%h want 1 02", a_count, a_data);
    end
    tick();
    total++;
    if (a_count !== 2'd1 || a_data !== 8'h09) begin
      bad++;
      $display("FAIL fullpop_accept: got ac=%0d ad=%h want 1 09", a_count, a_data);
    end
    in_valid = 1'b0;
    tick();
    idle_inputs();
    total++;
    if (pa.size() !== 3 || pa[0] !== 8'h01 || pa[1] !== 8'h02 || pa[2] !== 8'h09 ||
        a_count !== 2'd0) begin
      bad++;
      $display("FAIL fullpop_order: got n=%0d ac=%0d want pops 01 02 09 and count 0",
               pa.size(), a_count);
    end
  endtask

  task automatic test_ordering_wrap();
    int idx = 0;
    int cyc = 0;
    bit exp_rdy;
    idle_inputs();
    pa.delete();
    while ((idx < 8 || qa.size() > 0) && cyc < 200) begin
      in_valid = (idx < 8);
      in_sel   = 1'b0;
      in_data  = 8'h10 + 8'(idx);
      a_ready  = (cyc % 2 == 0);
      #1;
      exp_rdy = qa.size() < DEPTH;
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL wrap_in_ready cyc=%0d: got %0b want %0b", cyc, in_ready, exp_rdy);
      end
      tick();
      if (in_valid && exp_rdy) idx++;
      total++;
      if (a_count !== 2'(qa.size()) || a_count > 2'd2 ||
          a_data !== (qa.size() > 0 ? qa[0] : 8'h00)) begin
        bad++;
        $display("FAIL wrap_state cyc=%0d: got ac=%0d ad=%h want %0d %h", cyc, a_count,
                 a_data, qa.size(), (qa.size() > 0 ? qa[0] : 8'h00));
      end
      cyc++;
    end
    total++;
    if (cyc >= 200) begin
      bad++;
      $display("FAIL wrap_timeout: got %0d cycles want < 200", cyc);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= pa.size() || pa[i] !== 8'h10 + 8'(i)) begin
        bad++;
        $display("FAIL wrap_order[%0d]: got %h want %h", i,
                 (i < pa.size() ? pa[i] : 8'hxx), 8'h10 + 8'(i));
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_stream();
    idle_inputs();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'($urandom);
    tick();
    in_data = 8'($urandom);
    tick();
    in_sel = 1'b1; in_data = 8'($urandom);
    tick();
    idle_inputs();
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({a_valid, b_valid, a_count, b_count, a_data, b_data} !== 22'd0) begin
      bad++;
      $display("FAIL midreset: got av=%0b bv=%0b ac=%0d bc=%0d ad=%h bd=%h want all 0",
               a_valid, b_valid, a_count, b_count, a_data, b_data);
    end
    qa.delete(); qb.delete();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h55;
    tick();
    idle_inputs();
    total++;
    if (b_data !== 8'h55 || b_count !== 2'd1 || a_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_first: got bd=%h bc=%0d av=%0b want 55 1 0",
               b_data, b_count, a_valid);
    end
    b_ready = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (b_valid !== 1'b0 || b_data !== 8'h00) begin
      bad++;
      $display("FAIL midreset_stale: got bv=%0b bd=%h want 0 00", b_valid, b_data);
    end
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom);
      in_data  = 8'($urandom);
      a_ready  = ($urandom_range(0, 2) != 0);
      b_ready  = ($urandom_range(0, 2) == 0);
      #1;
      exp_rdy = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rand_in_ready c=%0d: got %0b want %0b", c, in_ready, exp_rdy);
      end
      tick();
      total++;
      if (a_count !== 2'(qa.size()) || a_valid !== (qa.size() > 0) ||
          a_data !== (qa.size() > 0 ? qa[0] : 8'h00)) begin
        bad++;
        $display("FAIL rand_a c=%0d: got ac=%0d av=%0b ad=%h want %0d %h", c, a_count,
                 a_valid, a_data, qa.size(), (qa.size() > 0 ? qa[0] : 8'h00));
      end
      total++;
      if (b_count !== 2'(qb.size()) || b_valid !== (qb.size() > 0) ||
          b_data !== (qb.size() > 0 ? qb[0] : 8'h00)) begin
        bad++;
        $display("FAIL rand_b c=%0d: got bc=%0d bv=%0b bd=%h want %0d %h", c, b_count,
                 b_valid, b_data, qb.size(), (qb.size() > 0 ? qb[0] : 8'h00));
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_steering();
    test_full_backpressure();
    test_full_pop();
    test_ordering_wrap();
    test_reset_mid_stream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
